imem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single combinational read port of imem (6-bit word address in, 64-bit instruction out).
- Requester 0 is the fetch stage. Requester 1 is the debug/loader reader.
- Round-robin grant between the two, one access accepted per cycle.
- Response is registered: data, requester id and range error are returned on a shared response bus one cycle after acceptance.

---
 rtl/imem_arb_pkg.sv | 17 +
 rtl/imem.sv | 16 +
 rtl/rr_arb2.sv | 25 ++
 rtl/imem_arbiter.sv | 75 +++++++
 tb/tb_imem_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ---- imem_arb_pkg : shared types for the imem read-port arbiter ---- rev 1.0
package imem_arb_pkg;
  localparam int IMEM_DW = 64;
  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_DEBUG = 1'b1;

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} arb_state_t;

  typedef struct packed {
    logic               valid;
    logic               id;
    logic               err;
    logic [IMEM_DW-1:0] data;
  } imem_rsp_t;
endpackage
`default_nettype wire

// File: rtl/imem.sv
`default_nettype none
// ---- imem : combinational instruction ROM with a fixed hashed pattern ---- rev 1.0
module imem #(
  parameter int DEPTH = 32
) (
  input  logic [5:0]  addr,
  output logic [63:0] q
);
  localparam logic [63:0] c_SALT = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] c_MUL  = 64'h9E37_79B9_7F4A_7C15;

  // Unbacked addresses read a loud pattern so a missing zero-fill shows up.
  assign q = ({26'd0, addr} < DEPTH) ? (c_SALT ^ (64'(addr) * c_MUL))
                                     : 64'hDEAD_BEEF_DEAD_BEEF;
endmodule
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---- rr_arb2 : two-way round-robin grant with registered priority pointer ---- rev 1.0
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  arb_state_t r_state;

  // Grants are suppressed while reset is held so nothing is accepted.
  assign gnt0 = reset & req0 & (~req1 | (r_state == PRI0));
  assign gnt1 = reset & req1 & (~req0 | (r_state == PRI1));

  always_ff @(posedge clk) begin
    if (!reset)    r_state <= PRI0;
    else if (gnt0) r_state <= PRI1;
    else if (gnt1) r_state <= PRI0;
  end
endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ---- imem_arbiter : shares the imem read port between fetch and debug ---- rev 1.0
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 6,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  output logic          req1_ready,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_q,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any;
  logic          w_err;
  logic [AW-1:0] w_addr;
  imem_rsp_t     r_rsp;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_any      = w_gnt0 | w_gnt1;

  always_comb begin
    w_addr = '0;
    if (w_gnt0)      w_addr = req0_addr;
    else if (w_gnt1) w_addr = req1_addr;
  end

  assign mem_addr = w_addr;
  assign w_err    = ({1'b0, w_addr} >= c_DEPTH);

  // Payload only updates on a grant; it holds through idle cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp <= '0;
    end else begin
      r_rsp.valid <= w_any;
      if (w_any) begin
        r_rsp.id   <= w_gnt1 ? ID_DEBUG : ID_FETCH;
        r_rsp.err  <= w_err;
        r_rsp.data <= w_err ? '0 : IMEM_DW'(mem_q);
      end
    end
  end

  assign rsp_valid = r_rsp.valid;
  assign rsp_id    = r_rsp.id;
  assign rsp_err   = r_rsp.err;
  assign rsp_data  = DW'(r_rsp.data);
endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ---- tb_imem_arbiter : randomized, model-checked bench for imem_arbiter ---- rev 1.0
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [5:0]  req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready;
  logic [5:0]  mem_addr;
  logic [63:0] mem_q;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [63:0] rsp_data;

  int n_cmp = 0;
  int n_fail = 0;
  int m_pri = 0;  // requester that wins a tie: the one not granted most recently

  always #5 clk = ~clk;

  imem #(32) u_mem (.addr(mem_addr), .q(mem_q));

  imem_arbiter #(.DEPTH(32), .AW(6), .DW(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .mem_addr(mem_addr), .mem_q(mem_q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  function automatic int exp_gnt(bit v0, bit v1);
    if (v0 && v1) return m_pri;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [63:0] exp_data(logic [5:0] a);
    if (a >= 6'd32) return 64'd0;
    return 64'hA5A5_0000_0000_0000 ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [7:0] exp_hs(int g, logic [5:0] a0, logic [5:0] a1);
    if (g == 0) return {2'b10, a0};
    if (g == 1) return {2'b01, a1};
    return 8'd0;
  endfunction

  function automatic logic [66:0] exp_rsp(int g, logic [5:0] a0, logic [5:0] a1);
    logic [5:0] a;
    a = (g == 1) ? a1 : a0;
    return {1'b1, (g == 1), (a >= 6'd32), exp_data(a)};
  endfunction

  // Drives one cycle from just after an edge; samples handshake then response.
  task automatic do_cycle(input bit v0, input logic [5:0] a0, input bit v1, input logic [5:0] a1,
                          output logic [7:0] hs, output logic [66:0] rsp);
    req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    #1;
    hs = {req0_ready, req1_ready, mem_addr};
    @(posedge clk); #1;
    rsp = {rsp_valid, rsp_id, rsp_err, rsp_data};
  endtask

  task automatic do_reset(input int n);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    m_pri = 0;
  endtask

  task automatic test_reset;
    req0_valid = 1'b1; req0_addr = 6'd4; req1_valid = 1'b1; req1_addr = 6'd6;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({req0_ready, req1_ready, mem_addr} !== 8'd0) begin
        n_fail++; $display("FAIL reset_hs: got %h want 00", {req0_ready, req1_ready, mem_addr});
      end
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== 67'd0) begin
        n_fail++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_err, rsp_data});
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    m_pri = 0;
  endtask

  task automatic test_req1_alone;
    logic [7:0] hs; logic [66:0] rsp; int g;
    g = exp_gnt(0, 1);
    do_cycle(0, 6'd0, 1, 6'd5, hs, rsp);
    n_cmp++;
    if (hs !== exp_hs(g, 6'd0, 6'd5) || rsp !== exp_rsp(g, 6'd0, 6'd5)) begin
      n_fail++; $display("FAIL req1_alone: got %h/%h want %h/%h", hs, rsp, exp_hs(g, 6'd0, 6'd5), exp_rsp(g, 6'd0, 6'd5));
    end
    m_pri = 1 - g;
    do_cycle(1, 6'd2, 1, 6'd5, hs, rsp);
    n_cmp++;
    if (hs !== {2'b10, 6'd2} || rsp !== {1'b1, 1'b0, 1'b0, exp_data(6'd2)}) begin
      n_fail++; $display("FAIL req1_alone_next: got %h/%h want grant to req0", hs, rsp);
    end
    m_pri = 1;
  endtask

  task automatic test_seq_fetch;
    logic [7:0] hs; logic [66:0] rsp; int g;
    for (int i = 0; i < 32; i++) begin
      g = exp_gnt(1, 0);
      do_cycle(1, 6'(i), 0, 6'd0, hs, rsp);
      n_cmp++;
      if (hs !== exp_hs(g, 6'(i), 6'd0) || rsp !== exp_rsp(g, 6'(i), 6'd0)) begin
        n_fail++; $display("FAIL seq_fetch addr %0d: got %h/%h want %h/%h", i, hs, rsp, exp_hs(g, 6'(i), 6'd0), exp_rsp(g, 6'(i), 6'd0));
      end
      m_pri = 1 - g;
    end
  endtask

  task automatic test_contention;
    logic [7:0] hs; logic [66:0] rsp; int g;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      g = exp_gnt(1, 1);
      do_cycle(1, 6'd3, 1, 6'd7, hs, rsp);
      n_cmp++;
      if (hs !== exp_hs(g, 6'd3, 6'd7) || rsp !== exp_rsp(g, 6'd3, 6'd7) || rsp[65] !== i[0]) begin
        n_fail++; $display("FAIL contention cyc %0d: got %h/%h want %h/%h", i, hs, rsp, exp_hs(g, 6'd3, 6'd7), exp_rsp(g, 6'd3, 6'd7));
      end
      m_pri = 1 - g;
    end
  endtask

  task automatic test_range;
    logic [7:0] hs; logic [66:0] rsp; int g;
    g = exp_gnt(1, 0);
    do_cycle(1, 6'd40, 0, 6'd0, hs, rsp);
    n_cmp++;
    if (rsp !== {1'b1, 1'b0, 1'b1, 64'd0} || hs !== exp_hs(g, 6'd40, 6'd0)) begin
      n_fail++; $display("FAIL range_err: got %h/%h want %h/%h", hs, rsp, exp_hs(g, 6'd40, 6'd0), {1'b1, 1'b0, 1'b1, 64'd0});
    end
    m_pri = 1 - g;
    g = exp_gnt(1, 1);
    do_cycle(1, 6'd63, 1, 6'd31, hs, rsp);
    n_cmp++;
    if (g != 1 || hs !== exp_hs(g, 6'd63, 6'd31) || rsp !== exp_rsp(g, 6'd63, 6'd31)) begin
      n_fail++; $display("FAIL range_rotate: got %h/%h want %h/%h", hs, rsp, exp_hs(1, 6'd63, 6'd31), exp_rsp(1, 6'd63, 6'd31));
    end
    m_pri = 1 - g;
  endtask

  task automatic test_reset_mid;
    logic [7:0] hs; logic [66:0] rsp;
    do_cycle(1, 6'd9, 0, 6'd0, hs, rsp);
    n_cmp++;
    if (rsp !== exp_rsp(0, 6'd9, 6'd0)) begin
      n_fail++; $display("FAIL reset_mid_accept: got %h want %h", rsp, exp_rsp(0, 6'd9, 6'd0));
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_cycle(1, 6'd10, 1, 6'd11, hs, rsp);
      n_cmp++;
      if (hs !== 8'd0 || rsp !== 67'd0) begin
        n_fail++; $display("FAIL reset_mid_hold cyc %0d: got %h/%h want 00/0", i, hs, rsp);
      end
    end
    reset = 1'b1;
    m_pri = 0;
    do_cycle(1, 6'd12, 1, 6'd13, hs, rsp);
    n_cmp++;
    if (hs !== {2'b10, 6'd12} || rsp !== exp_rsp(0, 6'd12, 6'd13)) begin
      n_fail++; $display("FAIL reset_mid_release: got %h/%h want grant to req0", hs, rsp);
    end
    m_pri = 1;
  endtask

  task automatic test_idle;
    logic [7:0] hs; logic [66:0] rsp; int g;
    for (int i = 0; i < 10; i++) begin
      do_cycle(0, 6'($urandom), 0, 6'($urandom), hs, rsp);
      n_cmp++;
      if (hs !== 8'd0 || rsp[66] !== 1'b0) begin
        n_fail++; $display("FAIL idle cyc %0d: got hs %h valid %b want 00/0", i, hs, rsp[66]);
      end
    end
    g = exp_gnt(1, 1);
    do_cycle(1, 6'd1, 1, 6'd2, hs, rsp);
    n_cmp++;
    if (hs !== exp_hs(g, 6'd1, 6'd2) || rsp !== exp_rsp(g, 6'd1, 6'd2)) begin
      n_fail++; $display("FAIL idle_state_kept: got %h/%h want %h/%h", hs, rsp, exp_hs(g, 6'd1, 6'd2), exp_rsp(g, 6'd1, 6'd2));
    end
    m_pri = 1 - g;
  endtask

  task automatic test_random;
    logic [7:0] hs; logic [66:0] rsp; int g;
    bit p0 = 0, p1 = 0;
    logic [5:0] a0 = '0, a1 = '0;
    for (int i = 0; i < 300; i++) begin
      if (!p0) begin a0 = 6'($urandom); p0 = ($urandom_range(0, 2) != 0); end
      if (!p1) begin a1 = 6'($urandom); p1 = ($urandom_range(0, 2) != 0); end
      g = exp_gnt(p0, p1);
      do_cycle(p0, a0, p1, a1, hs, rsp);
      n_cmp++;
      if (hs !== exp_hs(g, a0, a1)) begin
        n_fail++; $display("FAIL random_hs cyc %0d: got %h want %h", i, hs, exp_hs(g, a0, a1));
      end
      n_cmp++;
      if (g < 0 ? (rsp[66] !== 1'b0) : (rsp !== exp_rsp(g, a0, a1))) begin
        n_fail++; $display("FAIL random_rsp cyc %0d: got %h want %h", i, rsp, (g < 0) ? 67'd0 : exp_rsp(g, a0, a1));
      end
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
      if (g >= 0) m_pri = 1 - g;
    end
  endtask

  initial begin
    test_reset;
    test_req1_alone;
    test_seq_fetch;
    test_contention;
    test_range;
    test_reset_mid;
    test_idle;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
